// File: rtl/flit_injector.sv
// flit_injector: queues core packets for mesh injection and loops self-addressed packets back locally.
// Optional age stamping of queued flits is enabled by defining INJ_AGE_STAMP_EN.
module flit_injector #(
  parameter int ADDRBITS2    = 4,
  parameter int DATABITS     = 32,
  parameter int AGEBITS      = 8,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [ADDRBITS2-1:0]                      ID,
  input  logic                                      req_valid,
  output logic                                      req_ready,
  input  logic [ADDRBITS2-1:0]                      req_dst,
  input  logic [DATABITS-1:0]                       req_data,
  output logic                                      inj_valid,
  input  logic                                      inj_grant,
  output logic [2*ADDRBITS2+AGEBITS+DATABITS-1:0]   inj_flit,
  output logic                                      loop_valid,
  output logic [DATABITS-1:0]                       loop_data,
  output logic                                      starve
);

  localparam int PTRBITS  = $clog2(DEPTH);
  localparam int CNTBITS  = $clog2(DEPTH + 1);
  localparam int WAITBITS = $clog2(STARVE_LIMIT + 1);

  logic                 ready_en_r;
  logic [CNTBITS-1:0]   count_r;
  logic [PTRBITS-1:0]   wr_ptr_r;
  logic [PTRBITS-1:0]   rd_ptr_r;
  logic [WAITBITS-1:0]  wait_r;
  logic                 loop_valid_r;
  logic [DATABITS-1:0]  loop_data_r;
  logic [ADDRBITS2-1:0] dst_mem_r  [DEPTH];
  logic [DATABITS-1:0]  data_mem_r [DEPTH];
  logic [AGEBITS-1:0]   head_age_s;

  logic full_s;
  logic accept_s;
  logic self_s;
  logic push_s;
  logic pop_s;

  // req_ready ignores a same-cycle pop so the accept path stays short
  assign full_s     = (count_r == CNTBITS'(DEPTH));
  assign req_ready  = ready_en_r && !full_s;
  assign accept_s   = req_valid && req_ready;
  assign self_s     = (req_dst == ID);
  assign push_s     = accept_s && !self_s;
  assign inj_valid  = (count_r != {CNTBITS{1'b0}});
  assign pop_s      = inj_valid && inj_grant;
  assign inj_flit   = {dst_mem_r[rd_ptr_r], ID, head_age_s, data_mem_r[rd_ptr_r]};
  assign starve     = (wait_r == WAITBITS'(STARVE_LIMIT));
  assign loop_valid = loop_valid_r;
  assign loop_data  = loop_data_r;

  // Ready is held low through reset and rises on the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  // Queue occupancy and circular pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= {CNTBITS{1'b0}};
      wr_ptr_r <= {PTRBITS{1'b0}};
      rd_ptr_r <= {PTRBITS{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTRBITS'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTRBITS'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNTBITS'(1);
        2'b01:   count_r <= count_r - CNTBITS'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage; contents are meaningless while count_r says so, hence no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      dst_mem_r[wr_ptr_r]  <= req_dst;
      data_mem_r[wr_ptr_r] <= req_data;
    end
  end

  // Head-of-line wait counter, saturating at the starvation threshold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_r <= {WAITBITS{1'b0}};
    end else if (pop_s || !inj_valid) begin
      wait_r <= {WAITBITS{1'b0}};
    end else if (wait_r != WAITBITS'(STARVE_LIMIT)) begin
      wait_r <= wait_r + WAITBITS'(1);
    end else begin
      wait_r <= wait_r;
    end
  end

  // Self-addressed packets bypass the queue as a one-cycle local delivery
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loop_valid_r <= 1'b0;
      loop_data_r  <= {DATABITS{1'b0}};
    end else begin
      loop_valid_r <= accept_s && self_s;
      loop_data_r  <= (accept_s && self_s) ? req_data : loop_data_r;
    end
  end

`ifdef INJ_AGE_STAMP_EN
  logic [AGEBITS-1:0] age_r;
  logic [AGEBITS-1:0] age_mem_r [DEPTH];

  // Free-running age clock used for oldest-first deflection arbitration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_r <= {AGEBITS{1'b0}};
    end else begin
      age_r <= age_r + AGEBITS'(1);
    end
  end

  // Stamp each enqueued flit with the age at acceptance
  always_ff @(posedge clk) begin
    if (push_s) begin
      age_mem_r[wr_ptr_r] <= age_r;
    end
  end

  assign head_age_s = age_mem_r[rd_ptr_r];
`else
  assign head_age_s = {AGEBITS{1'b0}};
`endif

endmodule

// File: tb/tb_flit_injector.sv
// tb_flit_injector: directed self-checking bench for flit_injector with a queue reference model.
// Age expectations follow INJ_AGE_STAMP_EN when it is defined.
module tb_flit_injector;

  logic        clk;
  logic        rst_n;
  logic [3:0]  id;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_dst;
  logic [31:0] req_data;
  logic        inj_valid;
  logic        inj_grant;
  logic [47:0] inj_flit;
  logic        loop_valid;
  logic [31:0] loop_data;
  logic        starve;

  int checks = 0;
  int errors = 0;
  logic [47:0] q_m [$];
  logic [7:0]  age_m;

  flit_injector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ID         (id),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dst    (req_dst),
    .req_data   (req_data),
    .inj_valid  (inj_valid),
    .inj_grant  (inj_grant),
    .inj_flit   (inj_flit),
    .loop_valid (loop_valid),
    .loop_data  (loop_data),
    .starve     (starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference age clock: counts edges since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) age_m <= 8'h00;
    else        age_m <= age_m + 8'h01;
  end

  function automatic logic [7:0] exp_age();
`ifdef INJ_AGE_STAMP_EN
    return age_m;
`else
    return 8'h00;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [47:0] f;
    rst_n = 1'b0; id = 4'b0101; req_valid = 1'b0; req_dst = 4'h0;
    req_data = 32'h0; inj_grant = 1'b0;
    repeat (3) step();
    check("rst_ready", {63'd0, req_ready}, 64'd0);
    check("rst_inj_valid", {63'd0, inj_valid}, 64'd0);
    check("rst_loop_valid", {63'd0, loop_valid}, 64'd0);
    check("rst_starve", {63'd0, starve}, 64'd0);
    rst_n = 1'b1;
    #1 check("ready_before_edge", {63'd0, req_ready}, 64'd0);
    step();
    check("ready_after_edge", {63'd0, req_ready}, 64'd1);

    // Single packet to a remote node, granted immediately
    req_valid = 1'b1; req_dst = 4'b1010; req_data = 32'hDEADBEEF; inj_grant = 1'b1;
    f = {4'b1010, 4'b0101, exp_age(), 32'hDEADBEEF};
    step();
    req_valid = 1'b0;
    check("single_valid", {63'd0, inj_valid}, 64'd1);
    check("single_flit", {16'd0, inj_flit}, {16'd0, f});
    step();
    check("single_popped", {63'd0, inj_valid}, 64'd0);

    // Self-addressed loopback
    req_valid = 1'b1; req_dst = 4'b0101; req_data = 32'h00001234;
    step();
    req_valid = 1'b0;
    check("loop_valid", {63'd0, loop_valid}, 64'd1);
    check("loop_data", {32'd0, loop_data}, {32'd0, 32'h00001234});
    check("loop_no_inj", {63'd0, inj_valid}, 64'd0);
    step();
    check("loop_pulse_end", {63'd0, loop_valid}, 64'd0);
    check("loop_still_empty", {63'd0, inj_valid}, 64'd0);

    // Fill the queue with grant low
    inj_grant = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      req_valid = 1'b1; req_dst = 4'(i); req_data = 32'hA000 + 32'(i);
      q_m.push_back({4'(i), 4'b0101, exp_age(), 32'hA000 + 32'(i)});
      step();
    end
    req_dst = 4'h7; req_data = 32'h99;
    check("full_ready_low", {63'd0, req_ready}, 64'd0);
    step();
    check("full_still_low", {63'd0, req_ready}, 64'd0);
    check("full_head_kept", {16'd0, inj_flit}, {16'd0, q_m[0]});

    // Drain while offering continuously; order must match the model
    inj_grant = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic rdy;
      req_data = 32'h100 + 32'(k);
      rdy = (q_m.size() != 4);
      check("stream_ready", {63'd0, req_ready}, {63'd0, rdy});
      check("stream_head", {16'd0, inj_flit}, {16'd0, q_m[0]});
      f = {4'h7, 4'b0101, exp_age(), 32'h100 + 32'(k)};
      void'(q_m.pop_front());
      if (rdy) q_m.push_back(f);
      step();
    end
    req_valid = 1'b0;
    for (int k = 0; k < 8 && q_m.size() > 0; k++) begin
      check("drain_head", {16'd0, inj_flit}, {16'd0, q_m[0]});
      void'(q_m.pop_front());
      step();
    end
    check("drained", {63'd0, inj_valid}, 64'd0);

    // Starvation timing with one flit held
    inj_grant = 1'b0; req_valid = 1'b1; req_dst = 4'h3; req_data = 32'h5;
    step();
    req_valid = 1'b0;
    check("starve_start_valid", {63'd0, inj_valid}, 64'd1);
    repeat (14) step();
    check("starve_at_14", {63'd0, starve}, 64'd0);
    step();
    check("starve_at_15", {63'd0, starve}, 64'd1);
    step();
    check("starve_saturate", {63'd0, starve}, 64'd1);
    inj_grant = 1'b1;
    step();
    check("starve_cleared", {63'd0, starve}, 64'd0);
    check("starve_popped", {63'd0, inj_valid}, 64'd0);

    // Grant while empty must be ignored
    repeat (2) step();
    inj_grant = 1'b0; req_valid = 1'b1; req_dst = 4'h9; req_data = 32'h77;
    f = {4'h9, 4'b0101, exp_age(), 32'h77};
    step();
    req_valid = 1'b0;
    check("idle_grant_ignored", {16'd0, inj_flit}, {16'd0, f});
    step();
    check("idle_grant_valid", {63'd0, inj_valid}, 64'd1);

    // Asynchronous reset mid-operation with three queued flits
    for (int i = 0; i < 2; i++) begin
      req_valid = 1'b1; req_dst = 4'hC; req_data = 32'(i);
      step();
    end
    req_valid = 1'b0;
    repeat (15) step();
    check("pre_reset_starve", {63'd0, starve}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_inj_valid", {63'd0, inj_valid}, 64'd0);
    check("async_ready", {63'd0, req_ready}, 64'd0);
    check("async_starve", {63'd0, starve}, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_reset_ready", {63'd0, req_ready}, 64'd1);
    inj_grant = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("post_reset_no_flit", {63'd0, inj_valid}, 64'd0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
